pic_inta_sequencer: RTL and testbench
=====================================

Name: pic_inta_sequencer

Overview:
- Interrupt acknowledge controller for the 8259-style PIC.
- Takes masked pending requests from the IRR block and owns the In-Service Register (ISR).
- Arbitrates requests against in-service levels (fully nested, with optional rotation), drives INT to the CPU, and runs the two-pulse INTA sequence that places the vector on the data bus.
- Handles AEOI, specific EOI and non-specific EOI, and tells the IRR block which request bit to clear.

Parameters:
- VEC_BITS, 5: width of the vector base field (vector = {vector_base, level[2:0]}).
- SPURIOUS_LVL, 7: level reported when an INTA arrives with no valid candidate.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- irr  in  8  pending requests, already masked
- inta_n  in  1  CPU acknowledge, active low, sampled on clk
- aeoi  in  1  automatic EOI mode
- rotate_on_eoi  in  1  rotate priority when a level is cleared
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific EOI
- eoi_level  in  3  target level for specific EOI
- vector_base  in  VEC_BITS  ICW2 T7..T3
- int_out  out  1  interrupt request to CPU
- isr  out  8  in-service register
- clear_irr  out  8  one-cycle one-hot clear pulse to the IRR block
- data_out  out  8  vector byte
- data_oe  out  1  data bus drive enable

Behaviour:
- Reset (synchronous, active-high): isr=0, int_out=0, clear_irr=0, data_out=0, data_oe=0, lowest_prio=7, state IDLE, inta_q=1.
- Priority rank of IR i = (i - lowest_prio - 1) mod 8; rank 0 is highest. After reset, IR0 is highest and IR7 lowest.
- Candidate = highest-rank set bit of irr whose rank is strictly better than the highest-rank set bit of isr. If isr=0, any irr bit qualifies.
- INTA falling edge = inta_q==1 and inta_n==0. inta_q is inta_n registered every cycle.
- FSM states: IDLE, REQ, ACK1, ACK2.
- IDLE: if a candidate exists, go to REQ and set int_out=1 on the next edge (1-cycle latency).
- REQ:
  - If the candidate vanishes before an INTA edge, return to IDLE and set int_out=0.
  - On an INTA edge, latch lvl = candidate (or SPURIOUS_LVL if none), then go to ACK1. int_out=0.
  - If the candidate was valid: set isr[lvl] and pulse clear_irr[lvl] for exactly one cycle.
  - If the edge was spurious: leave isr unchanged and keep clear_irr=0.
- ACK1: data_oe=0 (first pulse carries no data). On the second INTA edge, set data_out={vector_base, lvl} and data_oe=1, then go to ACK2.
- ACK2:
  - data_oe stays 1 while inta_n==0.
  - On the cycle after inta_n is sampled high: data_oe=0.
  - If aeoi and the acknowledge was not spurious: clear isr[lvl], and if rotate_on_eoi also set lowest_prio=lvl.
  - Return to IDLE.
- int_out is never asserted outside REQ. A new request is not resolved until the FSM is back in IDLE.
- EOI is accepted in any state when eoi_valid=1:
  - Specific: clear isr[eoi_level].
  - Non-specific: clear the highest-rank set isr bit. Ignored if isr=0.
  - If rotate_on_eoi and a bit was actually cleared, set lowest_prio to the cleared level.
  - A specific EOI to an already-clear bit changes nothing, including no rotation.
- Simultaneous ISR set (INTA edge) and EOI in the same cycle:
  - The EOI target is computed from the pre-cycle isr.
  - If set and clear hit the same bit, the set wins.
- AEOI clear and an EOI in the same cycle: both clears apply. The AEOI rotation update takes precedence.
- Reset asserted mid-sequence: everything returns to reset values on that edge. data_oe drops immediately (next edge), with no partial vector.
- isr only changes through the INTA set, AEOI and EOI paths.

Test Plan:
- Reset, vector_base=5'b01000, irr=8'h24 → int_out=1 one cycle later. INTA1 → isr=8'h04, clear_irr=8'h04 for one cycle. INTA2 → data_out=8'h42, data_oe=1. After release, data_oe=0 and int_out stays 0 until a non-specific EOI, after which isr=0 and IR5 is then requested.
- isr=8'h04 in service, irr=8'h08 → int_out stays 0. Then irr=8'h01 → IR0 nests: isr=8'h05, vector 8'h40.
- irr=8'h10 asserted then dropped before INTA1 → int_out returns to 0. An INTA pulse pair with no candidate → data_out=8'h47, isr unchanged, clear_irr=0.
- aeoi=1, rotate_on_eoi=1, irr=8'h09 → IR0 is served and auto-cleared, lowest_prio=0. The next sequence serves IR3 (vector 8'h43), and IR0 now ranks lowest.
- isr=8'h06, specific EOI level 2 in the same cycle as an INTA1 edge for IR0 → isr=8'h03.
- Reset asserted while in ACK2 with data_oe=1 → next cycle data_oe=0, isr=0, int_out=0, state IDLE.

Source files
------------

// File: rtl/pic_inta_sequencer.sv
// 8259-style interrupt acknowledge sequencer: owns the ISR, arbitrates masked
// requests with optional priority rotation and runs the two-pulse INTA handshake.
module pic_inta_sequencer #(
    parameter int VEC_BITS     = 5,
    parameter int SPURIOUS_LVL = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          irr,
    input  logic                inta_n,
    input  logic                aeoi,
    input  logic                rotate_on_eoi,
    input  logic                eoi_valid,
    input  logic                eoi_specific,
    input  logic [2:0]          eoi_level,
    input  logic [VEC_BITS-1:0] vector_base,
    output logic                int_out,
    output logic [7:0]          isr,
    output logic [7:0]          clear_irr,
    output logic [7:0]          data_out,
    output logic                data_oe
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK1 = 2'd2;
    localparam logic [1:0] ACK2 = 2'd3;

    logic [1:0] state;
    logic [2:0] lowest_prio;
    logic [2:0] lvl;
    logic       spurious;
    logic       inta_q;

    logic       inta_edge;
    logic [2:0] idx;
    logic       irr_found, isr_found;
    logic [2:0] irr_k, isr_k;
    logic [2:0] cand_lvl, isr_top_lvl;
    logic       cand_valid;
    logic       eoi_hit;
    logic [2:0] eoi_lvl;
    logic [7:0] eoi_clr, aeoi_clr, set_mask, isr_next;
    logic       aeoi_fire, set_fire;
    logic [2:0] lp_next;

    assign inta_edge = inta_q & ~inta_n;

    // Walk the ranks from lowest to highest so the best-ranked set bit ends up latched.
    always_comb begin
        idx       = 3'd0;
        irr_found = 1'b0;
        isr_found = 1'b0;
        irr_k     = 3'd0;
        isr_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = lowest_prio + 3'd1 + 3'(k);
            if (irr[idx]) begin
                irr_found = 1'b1;
                irr_k     = 3'(k);
            end
            if (isr[idx]) begin
                isr_found = 1'b1;
                isr_k     = 3'(k);
            end
        end
        cand_lvl    = lowest_prio + 3'd1 + irr_k;
        isr_top_lvl = lowest_prio + 3'd1 + isr_k;
        cand_valid  = irr_found && (!isr_found || (irr_k < isr_k));
    end

    // The INTA set is OR'd in after all clears so it wins on a same-bit collision.
    always_comb begin
        eoi_hit = 1'b0;
        eoi_lvl = 3'd0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_lvl = eoi_level;
                eoi_hit = isr[eoi_level];
            end else begin
                eoi_lvl = isr_top_lvl;
                eoi_hit = isr_found;
            end
        end
        eoi_clr   = eoi_hit ? (8'b1 << eoi_lvl) : 8'b0;
        aeoi_fire = (state == ACK2) && inta_n && aeoi && !spurious;
        aeoi_clr  = aeoi_fire ? (8'b1 << lvl) : 8'b0;
        set_fire  = (state == REQ) && inta_edge && cand_valid;
        set_mask  = set_fire ? (8'b1 << cand_lvl) : 8'b0;
        isr_next  = (isr & ~(eoi_clr | aeoi_clr)) | set_mask;
        lp_next   = lowest_prio;
        if (rotate_on_eoi && eoi_hit)
            lp_next = eoi_lvl;
        if (rotate_on_eoi && aeoi_fire)
            lp_next = lvl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            isr         <= 8'b0;
            int_out     <= 1'b0;
            clear_irr   <= 8'b0;
            data_out    <= 8'b0;
            data_oe     <= 1'b0;
            lowest_prio <= 3'd7;
            lvl         <= 3'd0;
            spurious    <= 1'b0;
            inta_q      <= 1'b1;
        end else begin
            inta_q      <= inta_n;
            isr         <= isr_next;
            lowest_prio <= lp_next;
            clear_irr   <= 8'b0;
            case (state)
                IDLE: begin
                    int_out <= cand_valid;
                    if (cand_valid)
                        state <= REQ;
                end
                REQ: begin
                    if (inta_edge) begin
                        int_out  <= 1'b0;
                        spurious <= !cand_valid;
                        lvl      <= cand_valid ? cand_lvl : 3'(SPURIOUS_LVL);
                        if (cand_valid)
                            clear_irr <= 8'b1 << cand_lvl;
                        state    <= ACK1;
                    end else if (!cand_valid) begin
                        int_out <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACK1: begin
                    data_oe <= 1'b0;
                    if (inta_edge) begin
                        data_out <= 8'({vector_base, lvl});
                        data_oe  <= 1'b1;
                        state    <= ACK2;
                    end
                end
                default: begin
                    if (inta_n) begin
                        data_oe <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: table of single acknowledge cycles plus
// hand-written nesting, spurious, AEOI/rotation, EOI collision and reset sequences.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr;
    logic       inta_n;
    logic       aeoi;
    logic       rotate_on_eoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] irr;
        logic [4:0] vb;
        logic       exp_int;
        logic [7:0] exp_isr;
        logic [7:0] exp_clear;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    pic_inta_sequencer #(.VEC_BITS(5), .SPURIOUS_LVL(7)) dut (
        .clk(clk),
        .reset(reset),
        .irr(irr),
        .inta_n(inta_n),
        .aeoi(aeoi),
        .rotate_on_eoi(rotate_on_eoi),
        .eoi_valid(eoi_valid),
        .eoi_specific(eoi_specific),
        .eoi_level(eoi_level),
        .vector_base(vector_base),
        .int_out(int_out),
        .isr(isr),
        .clear_irr(clear_irr),
        .data_out(data_out),
        .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] irr_v, input logic inta_v);
        irr    = irr_v;
        inta_n = inta_v;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic resetDut(input logic check_values);
        reset         = 1'b1;
        irr           = 8'h00;
        inta_n        = 1'b1;
        aeoi          = 1'b0;
        rotate_on_eoi = 1'b0;
        eoi_valid     = 1'b0;
        eoi_specific  = 1'b0;
        eoi_level     = 3'd0;
        tick();
        if (check_values) begin
            checkOutput("reset int_out", {7'd0, int_out}, 8'h00);
            checkOutput("reset isr", isr, 8'h00);
            checkOutput("reset clear_irr", clear_irr, 8'h00);
            checkOutput("reset data_out", data_out, 8'h00);
            checkOutput("reset data_oe", {7'd0, data_oe}, 8'h00);
        end
        reset = 1'b0;
    endtask

    // Full two-pulse acknowledge starting from REQ; the bench plays the IRR block by
    // dropping the acknowledged request bit after the clear pulse.
    task automatic serve(input string tag, input logic [7:0] exp_isr,
                         input logic [7:0] exp_clear, input logic [7:0] exp_data);
        applyStimulus(irr, 1'b0);
        checkOutput({tag, " int_out after INTA1"}, {7'd0, int_out}, 8'h00);
        checkOutput({tag, " isr after INTA1"}, isr, exp_isr);
        checkOutput({tag, " clear_irr pulse"}, clear_irr, exp_clear);
        checkOutput({tag, " data_oe in ACK1"}, {7'd0, data_oe}, 8'h00);
        applyStimulus(irr & ~exp_clear, 1'b1);
        checkOutput({tag, " clear_irr one cycle"}, clear_irr, 8'h00);
        applyStimulus(irr, 1'b0);
        checkOutput({tag, " vector"}, data_out, exp_data);
        checkOutput({tag, " data_oe on INTA2"}, {7'd0, data_oe}, 8'h01);
        applyStimulus(irr, 1'b1);
        checkOutput({tag, " data_oe after release"}, {7'd0, data_oe}, 8'h00);
    endtask

    initial begin
        vecs[0] = '{irr: 8'h01, vb: 5'b01000, exp_int: 1'b1, exp_isr: 8'h01, exp_clear: 8'h01, exp_data: 8'h40};
        vecs[1] = '{irr: 8'h80, vb: 5'b11111, exp_int: 1'b1, exp_isr: 8'h80, exp_clear: 8'h80, exp_data: 8'hFF};
        vecs[2] = '{irr: 8'hF0, vb: 5'b10101, exp_int: 1'b1, exp_isr: 8'h10, exp_clear: 8'h10, exp_data: 8'hAC};
        vecs[3] = '{irr: 8'h0A, vb: 5'b00000, exp_int: 1'b1, exp_isr: 8'h02, exp_clear: 8'h02, exp_data: 8'h01};
        vecs[4] = '{irr: 8'h00, vb: 5'b01000, exp_int: 1'b0, exp_isr: 8'h00, exp_clear: 8'h00, exp_data: 8'h00};
        vecs[5] = '{irr: 8'hC0, vb: 5'b00110, exp_int: 1'b1, exp_isr: 8'h40, exp_clear: 8'h40, exp_data: 8'h36};

        vector_base = 5'b01000;
        resetDut(1'b1);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            resetDut(1'b0);
            vector_base = vecs[i].vb;
            applyStimulus(vecs[i].irr, 1'b1);
            checkOutput($sformatf("vec%0d int_out", i), {7'd0, int_out}, {7'd0, vecs[i].exp_int});
            if (vecs[i].exp_int)
                serve($sformatf("vec%0d", i), vecs[i].exp_isr, vecs[i].exp_clear, vecs[i].exp_data);
        end

        $display("[TB] basic acknowledge and non-specific EOI");
        resetDut(1'b0);
        vector_base = 5'b01000;
        applyStimulus(8'h24, 1'b1);
        checkOutput("basic int_out latency", {7'd0, int_out}, 8'h01);
        serve("basic", 8'h04, 8'h04, 8'h42);
        applyStimulus(irr, 1'b1);
        checkOutput("basic IR5 blocked", {7'd0, int_out}, 8'h00);
        eoi_valid    = 1'b1;
        eoi_specific = 1'b0;
        applyStimulus(irr, 1'b1);
        eoi_valid = 1'b0;
        checkOutput("basic isr after EOI", isr, 8'h00);
        applyStimulus(irr, 1'b1);
        checkOutput("basic IR5 requested", {7'd0, int_out}, 8'h01);

        $display("[TB] nesting");
        resetDut(1'b0);
        applyStimulus(8'h04, 1'b1);
        serve("nest IR2", 8'h04, 8'h04, 8'h42);
        applyStimulus(8'h08, 1'b1);
        applyStimulus(8'h08, 1'b1);
        checkOutput("nest IR3 blocked", {7'd0, int_out}, 8'h00);
        applyStimulus(8'h09, 1'b1);
        checkOutput("nest IR0 int_out", {7'd0, int_out}, 8'h01);
        serve("nest IR0", 8'h05, 8'h01, 8'h40);

        $display("[TB] vanishing request and spurious acknowledge");
        resetDut(1'b0);
        applyStimulus(8'h10, 1'b1);
        checkOutput("vanish int_out up", {7'd0, int_out}, 8'h01);
        applyStimulus(8'h00, 1'b1);
        checkOutput("vanish int_out down", {7'd0, int_out}, 8'h00);
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("spurious isr", isr, 8'h00);
        checkOutput("spurious clear_irr", clear_irr, 8'h00);
        checkOutput("spurious int_out", {7'd0, int_out}, 8'h00);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("spurious vector", data_out, 8'h47);
        checkOutput("spurious data_oe", {7'd0, data_oe}, 8'h01);
        applyStimulus(8'h00, 1'b1);
        checkOutput("spurious isr after", isr, 8'h00);

        $display("[TB] AEOI with rotation");
        resetDut(1'b0);
        aeoi          = 1'b1;
        rotate_on_eoi = 1'b1;
        applyStimulus(8'h09, 1'b1);
        serve("aeoi IR0", 8'h01, 8'h01, 8'h40);
        checkOutput("aeoi IR0 auto-cleared", isr, 8'h00);
        applyStimulus(8'h09, 1'b1);
        checkOutput("aeoi int_out", {7'd0, int_out}, 8'h01);
        serve("aeoi IR3 over IR0", 8'h08, 8'h08, 8'h43);
        checkOutput("aeoi IR3 auto-cleared", isr, 8'h00);

        $display("[TB] specific EOI colliding with INTA1");
        resetDut(1'b0);
        applyStimulus(8'h04, 1'b1);
        serve("collide IR2", 8'h04, 8'h04, 8'h42);
        applyStimulus(8'h02, 1'b1);
        serve("collide IR1", 8'h06, 8'h02, 8'h41);
        applyStimulus(8'h01, 1'b1);
        checkOutput("collide IR0 int_out", {7'd0, int_out}, 8'h01);
        eoi_valid    = 1'b1;
        eoi_specific = 1'b1;
        eoi_level    = 3'd2;
        applyStimulus(8'h01, 1'b0);
        eoi_valid = 1'b0;
        checkOutput("collide isr", isr, 8'h03);
        checkOutput("collide clear_irr", clear_irr, 8'h01);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("collide vector", data_out, 8'h40);
        applyStimulus(8'h00, 1'b1);

        $display("[TB] reset during ACK2");
        resetDut(1'b0);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("midreset data_oe before", {7'd0, data_oe}, 8'h01);
        reset = 1'b1;
        tick();
        checkOutput("midreset data_oe", {7'd0, data_oe}, 8'h00);
        checkOutput("midreset isr", isr, 8'h00);
        checkOutput("midreset int_out", {7'd0, int_out}, 8'h00);
        checkOutput("midreset data_out", data_out, 8'h00);
        reset = 1'b0;
        applyStimulus(8'h02, 1'b1);
        checkOutput("midreset back in IDLE", {7'd0, int_out}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
